// File: rtl/img_pkg.sv
// Shared image geometry, pixel width and line feeder state encoding.
package img_pkg;

  localparam int IMG_WIDTH  = 512;
  localparam int IMG_HEIGHT = 512;
  localparam int PIX_W      = 8;
  localparam int CREDIT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_WAIT_CREDIT,
    ST_LINE,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  // Saturating credit update; inc and dec together cancel.
  function automatic logic [CREDIT_W-1:0] credit_next(
    input logic [CREDIT_W-1:0] c,
    input logic                inc,
    input logic                dec
  );
    logic [CREDIT_W-1:0] r;
    r = c;
    unique case ({inc, dec})
      2'b10:   r = (&c) ? c : c + CREDIT_W'(1);
      2'b01:   r = c - CREDIT_W'(1);
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel FIFO with occupancy; the writer guarantees no overflow.
module pix_skid_fifo
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [PIX_W-1:0] push_data,
  output logic             pop_valid,
  output logic [PIX_W-1:0] pop_data,
  input  logic             pop_ready,
  output logic [1:0]       count
);

  logic [PIX_W-1:0] mem [2];
  logic             wptr;
  logic             rptr;
  logic             pop;

  assign pop_valid = count != 2'd0;
  assign pop       = pop_valid & pop_ready;
  assign pop_data  = pop_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_valid) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      count <= count + 2'(push_valid) - 2'(pop);
    end
  end

endmodule

// File: rtl/line_feeder.sv
// Pumps frame-memory lines into the window pipeline, paced by
// line-consumed interrupts, then appends zero pad lines.
module line_feeder
  import img_pkg::*;
#(
  parameter int IMG_WIDTH   = img_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = img_pkg::IMG_HEIGHT,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 8,
  parameter int ADDR_W      = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [PIX_W-1:0]  i_rd_data,
  output logic              o_data_valid,
  output logic [PIX_W-1:0]  o_data,
  input  logic              i_data_ready,
  input  logic              i_intr,
  output logic              o_busy,
  output logic              o_done
);

  localparam int LINES  = IMG_HEIGHT + PAD_LINES;
  localparam int LINE_W = $clog2(LINES + 1);
  localparam int COL_W  = $clog2(IMG_WIDTH);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] PRIME_LAST = LINE_W'(PRIME_LINES - 1);
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(LINES - 1);
  localparam logic [LINE_W-1:0] IMG_LINES  = LINE_W'(IMG_HEIGHT);

  feeder_state_t state, state_nx;

  logic [LINE_W-1:0]   line_idx, line_nx;
  logic [COL_W-1:0]    col, col_nx;
  logic [CREDIT_W-1:0] credit;
  logic [ADDR_W-1:0]   addr;
  logic [PIX_W-1:0]    push_data;
  logic [1:0]          occ;
  logic [2:0]          pend;
  logic                intr_q;
  logic                intr_rise;
  logic                take_credit;
  logic                clear;
  logic                fetch;
  logic                in_img;
  logic                fly;
  logic                fly_zero;
  logic                pop;
  logic                space;

  // Count this cycle's pop as already gone so a steady stream has no bubbles.
  assign pop   = o_data_valid & i_data_ready;
  assign pend  = 3'(occ) + 3'(fly) - 3'(pop);
  assign space = pend < 3'd2;

  assign in_img    = line_idx < IMG_LINES;
  assign intr_rise = i_intr & ~intr_q & o_busy;

  assign addr      = ADDR_W'(line_idx) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col);
  assign o_rd_en   = fetch & in_img;
  assign o_rd_addr = o_rd_en ? addr : '0;
  assign push_data = fly_zero ? '0 : i_rd_data;

  always_comb begin
    state_nx    = state;
    line_nx     = line_idx;
    col_nx      = col;
    fetch       = 1'b0;
    take_credit = 1'b0;
    clear       = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          clear    = 1'b1;
          line_nx  = '0;
          col_nx   = '0;
          state_nx = ST_PRIME;
        end
      end
      ST_PRIME, ST_LINE: begin
        fetch = space;
        if (space) begin
          col_nx = col + COL_W'(1);
          if (col == COL_LAST) begin
            col_nx  = '0;
            line_nx = line_idx + LINE_W'(1);
            if (state == ST_PRIME) begin
              if (line_idx == PRIME_LAST) begin
                state_nx = ST_WAIT_CREDIT;
              end
            end else if (line_idx == LINE_LAST) begin
              state_nx = ST_DRAIN;
            end else begin
              state_nx = ST_WAIT_CREDIT;
            end
          end
        end
      end
      ST_WAIT_CREDIT: begin
        if (credit != '0) begin
          take_credit = 1'b1;
          state_nx    = ST_LINE;
        end
      end
      ST_DRAIN: begin
        if (pend == 3'd0) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy   = 1'b0;
        o_done   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state    <= ST_IDLE;
      line_idx <= '0;
      col      <= '0;
      credit   <= '0;
      intr_q   <= 1'b0;
      fly      <= 1'b0;
      fly_zero <= 1'b0;
    end else begin
      state    <= state_nx;
      line_idx <= line_nx;
      col      <= col_nx;
      intr_q   <= i_intr;
      fly      <= fetch;
      fly_zero <= fetch & ~in_img;
      credit   <= clear ? '0
                        : credit_next(credit, intr_rise, take_credit);
    end
  end

  pix_skid_fifo u_fifo (
    .clk        (axi_clk),
    .rst_n      (axi_reset_n),
    .push_valid (fly),
    .push_data  (push_data),
    .pop_valid  (o_data_valid),
    .pop_data   (o_data),
    .pop_ready  (i_data_ready),
    .count      (occ)
  );

endmodule

// File: tb/tb_line_feeder.sv
// Scoreboard bench for line_feeder on an 8x6 frame with 2 pad lines.
module tb_line_feeder;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int PRIME = 4;
  localparam int PAD   = 2;
  localparam int AW    = $clog2(W*H);
  localparam int LINES = H + PAD;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 0;
  logic          valid;
  logic [7:0]    data;
  logic          ready = 1;
  logic          intr = 0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  line_feeder #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PRIME_LINES(PRIME),
    .PAD_LINES  (PAD)
  ) dut (
    .axi_clk     (clk),
    .axi_reset_n (rst_n),
    .i_start     (start),
    .o_rd_en     (rd_en),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .o_data_valid(valid),
    .o_data      (data),
    .i_data_ready(ready),
    .i_intr      (intr),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Frame memory holds addr[7:0]; garbage when not read.
  always @(posedge clk) rd_data <= rd_en ? 8'(rd_addr) : 8'($urandom);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          nvec = 0;
  int          nerr = 0;
  byte unsigned sb[$];
  int          pop_cnt = 0;
  int          first_pop = 0;
  int          last_pop = 0;
  int          done_cnt = 0;
  bit          rand_ready = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: line l, column c of the streamed frame.
  task automatic push_line(input int l);
    for (int c = 0; c < W; c++)
      sb.push_back(l < H ? 8'(l*W + c) : 8'd0);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic pulse(input int hi);
    @(posedge clk); #1 intr = 1;
    repeat (hi) @(posedge clk);
    #1 intr = 0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    chk(nm, sb.size(), 0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int i = 0; i < budget && !(done_cnt > 0 && !busy); i++)
      @(negedge clk);
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_valid"}, valid, 0);
    chk({nm, "_data"}, data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  task automatic clr_stats();
    pop_cnt  = 0;
    done_cnt = 0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops scoreboard on every transfer, checks hold stability.
  initial begin
    logic       hold_q;
    logic [7:0] hold_data;
    hold_q    = 0;
    hold_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_q = 0;
      end else begin
        if (hold_q) begin
          chk("hold_valid", valid, 1);
          chk("hold_data", data, hold_data);
        end
        if (done) begin
          done_cnt++;
          chk("busy_with_done", busy, 0);
        end
        if (valid && ready) begin
          if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL extra_pixel: got %0d want none", data);
          end else begin
            chk("pixel", data, sb.pop_front());
          end
          if (pop_cnt == 0) first_pop = cyc;
          last_pop = cyc;
          pop_cnt++;
        end
        hold_q    = valid && !ready;
        hold_data = data;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero_outs("reset");
    rst_n = 1;

    // A: prime only, then one interrupt per line.
    clr_stats();
    for (int l = 0; l < PRIME; l++) push_line(l);
    do_start();
    chk("start_busy", busy, 1);
    chk("start_rd_en", rd_en, 1);
    @(posedge clk); #1 chk("valid_t0p1", valid, 0);
    @(posedge clk); #1 chk("valid_t0p2", valid, 1);
    wait_drain("prime_drain", 100);
    repeat (20) @(negedge clk);
    chk("prime_count", pop_cnt, PRIME*W);
    chk("prime_span", last_pop - first_pop, PRIME*W - 1);
    chk("prime_stall_valid", valid, 0);
    chk("prime_stall_busy", busy, 1);
    for (int l = PRIME; l < LINES; l++) begin
      push_line(l);
      pulse(1);
      wait_drain("line_drain", 100);
    end
    wait_done("a", 100);
    chk("a_total", pop_cnt, LINES*W);

    // B: three credits while priming.
    clr_stats();
    for (int l = 0; l < PRIME + 3; l++) push_line(l);
    do_start();
    repeat (3) pulse(1);
    wait_drain("burst_drain", 200);
    repeat (20) @(negedge clk);
    chk("burst_count", pop_cnt, (PRIME+3)*W);
    nvec++;
    if (last_pop - first_pop > (PRIME+3)*W - 1 + 3) begin
      nerr++;
      $display("FAIL burst_span: got %0d want <= %0d",
               last_pop - first_pop, (PRIME+3)*W + 2);
    end
    chk("burst_wait_valid", valid, 0);
    chk("burst_wait_busy", busy, 1);
    push_line(LINES - 1);
    pulse(1);
    wait_done("b", 200);

    // C: random ready, held interrupt, stray start.
    clr_stats();
    rand_ready = 1;
    for (int l = 0; l < PRIME; l++) push_line(l);
    do_start();
    wait_drain("rand_prime", 400);
    push_line(PRIME);
    pulse(10);
    wait_drain("held_drain", 400);
    repeat (20) @(negedge clk);
    chk("held_one_credit", pop_cnt, (PRIME+1)*W);
    for (int l = PRIME + 1; l < LINES; l++) begin
      repeat ($urandom_range(0, 12)) @(posedge clk);
      push_line(l);
      pulse($urandom_range(1, 3));
      if (l == PRIME + 1) do_start();
    end
    wait_done("c", 600);
    rand_ready = 0;

    // D: reset inside line 2, then a fresh full frame.
    clr_stats();
    for (int l = 0; l < PRIME; l++) push_line(l);
    do_start();
    for (int i = 0; i < 100 && pop_cnt < 2*W + 2; i++) @(negedge clk);
    chk("reach_line2", pop_cnt >= 2*W + 2, 1);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 chk_zero_outs("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    clr_stats();
    for (int l = 0; l < PRIME; l++) push_line(l);
    do_start();
    wait_drain("restart_prime", 100);
    for (int l = PRIME; l < LINES; l++) begin
      push_line(l);
      pulse(1);
      wait_drain("restart_line", 100);
    end
    wait_done("d", 100);
    chk("d_total", pop_cnt, LINES*W);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
